spi_master_multi: RTL and testbench

SPI_MASTER_MULTI -- requirements
Module: spi_master_multi

---
 rtl/spi_master_multi.sv | 207 ++++++++++++++++++++
 tb/tb_spi_master_multi.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_multi.sv
// SPI master with multiple chip selects, per-word mode/divider capture and
// optional chip-select hold between words.
// Optional receive path: define SPI_MASTER_MULTI_RX_EN to build the miso
// sampler, rx shift register, rx_valid and rx_data. Without it, miso is
// ignored, rx_valid/rx_data read 0, and transmit timing does not change.
module spi_master_multi #(
  parameter int DATA_W = 8,
  parameter int NUM_CS = 2,
  parameter int DIV_W  = 4,
  localparam int SEL_W = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic              clock,
  input  logic              reset,
  output logic              tx_ready,
  input  logic              tx_valid,
  input  logic [DATA_W-1:0] tx_data,
  input  logic [SEL_W-1:0]  tx_cs_sel,
  input  logic              tx_clear_cs,
  input  logic              cfg_cpol,
  input  logic              cfg_cpha,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic              miso,
  output logic              rx_valid,
  output logic [DATA_W-1:0] rx_data,
  output logic              sclk,
  output logic              mosi,
  output logic [NUM_CS-1:0] n_cs
);

  localparam int HC_W = $clog2(2 * DATA_W) + 1;
  localparam logic [HC_W-1:0] LAST_HALF = HC_W'(2 * DATA_W - 1);
  localparam logic [SEL_W:0] NUM_CS_V = (SEL_W + 1)'(NUM_CS);
  localparam logic [SEL_W-1:0] MAX_SEL = SEL_W'(NUM_CS - 1);

  typedef enum logic [1:0] {IDLE, CS_ASSERT, SHIFT, CS_DEASSERT} state_t;

  state_t           state;
  logic [DATA_W-1:0] tx_sr;
  logic [DIV_W-1:0] div_cnt;
  logic [DIV_W-1:0] div_q;
  logic [HC_W-1:0]  half_cnt;
  logic             cpol_q;
  logic             cpha_q;
  logic             clear_q;
  logic             cs_held;
  logic             switch_q;
  logic [SEL_W-1:0] cs_idx;
  logic [SEL_W-1:0] next_idx;
  logic [SEL_W-1:0] sel_clamped;
  logic             boundary;
  logic             last_half;

  // Out-of-range selects fold onto the highest chip select.
  assign sel_clamped = ({1'b0, tx_cs_sel} >= NUM_CS_V) ? MAX_SEL : tx_cs_sel;
  assign boundary    = (state == SHIFT) && (div_cnt == div_q);
  assign last_half   = boundary && (half_cnt == LAST_HALF);

  function automatic logic [NUM_CS-1:0] cs_low(input logic [SEL_W-1:0] idx);
    return ~(NUM_CS'(1) << idx);
  endfunction

  // Main sequencer: word accept, chip-select framing and serial shifting.
  // When switching targets the old select is released on entry to
  // CS_DEASSERT so the bus sees one full half-period with nothing selected.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      tx_ready <= 1'b0;
      sclk     <= 1'b0;
      mosi     <= 1'b0;
      n_cs     <= '1;
      tx_sr    <= '0;
      div_cnt  <= '0;
      div_q    <= '0;
      half_cnt <= '0;
      cpol_q   <= 1'b0;
      cpha_q   <= 1'b0;
      clear_q  <= 1'b0;
      cs_held  <= 1'b0;
      switch_q <= 1'b0;
      cs_idx   <= '0;
      next_idx <= '0;
    end else begin
      case (state)
        IDLE: begin
          tx_ready <= 1'b1;
          if (tx_valid && tx_ready) begin
            tx_ready <= 1'b0;
            tx_sr    <= tx_data;
            cpol_q   <= cfg_cpol;
            cpha_q   <= cfg_cpha;
            div_q    <= cfg_div;
            clear_q  <= tx_clear_cs;
            sclk     <= cfg_cpol;
            div_cnt  <= '0;
            half_cnt <= '0;
            if (!cs_held) begin
              state   <= CS_ASSERT;
              cs_idx  <= sel_clamped;
              n_cs    <= cs_low(sel_clamped);
              cs_held <= 1'b1;
            end else if (cs_idx == sel_clamped) begin
              state <= SHIFT;
              mosi  <= cfg_cpha ? 1'b0 : tx_data[DATA_W-1];
            end else begin
              state    <= CS_DEASSERT;
              next_idx <= sel_clamped;
              switch_q <= 1'b1;
              n_cs     <= '1;
              cs_held  <= 1'b0;
            end
          end
        end
        CS_ASSERT: begin
          if (div_cnt == div_q) begin
            div_cnt <= '0;
            state   <= SHIFT;
            mosi    <= cpha_q ? 1'b0 : tx_sr[DATA_W-1];
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        SHIFT: begin
          if (boundary) begin
            div_cnt  <= '0;
            sclk     <= ~sclk;
            half_cnt <= half_cnt + 1'b1;
            if (last_half) begin
              mosi <= 1'b0;
              if (clear_q) begin
                state <= CS_DEASSERT;
              end else begin
                state    <= IDLE;
                tx_ready <= 1'b1;
              end
            end else if (!half_cnt[0]) begin
              if (cpha_q) begin
                mosi  <= tx_sr[DATA_W-1];
                tx_sr <= tx_sr << 1;
              end
            end else begin
              if (!cpha_q) begin
                mosi  <= tx_sr[DATA_W-2];
                tx_sr <= tx_sr << 1;
              end
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        CS_DEASSERT: begin
          if (div_cnt == div_q) begin
            div_cnt <= '0;
            if (switch_q) begin
              state    <= CS_ASSERT;
              switch_q <= 1'b0;
              cs_idx   <= next_idx;
              n_cs     <= cs_low(next_idx);
              cs_held  <= 1'b1;
            end else begin
              state    <= IDLE;
              tx_ready <= 1'b1;
              n_cs     <= '1;
              cs_held  <= 1'b0;
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SPI_MASTER_MULTI_RX_EN
  logic [DATA_W-1:0] rx_sr;
  logic              sample_now;

  // CPHA=0 samples on leading edges, CPHA=1 on trailing edges.
  assign sample_now = boundary && (~half_cnt[0] ^ cpha_q);

  // Receive shifter; the final CPHA=1 sample lands straight in rx_data.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_sr    <= '0;
      rx_valid <= 1'b0;
      rx_data  <= '0;
    end else begin
      rx_valid <= 1'b0;
      if (sample_now) begin
        rx_sr <= {rx_sr[DATA_W-2:0], miso};
      end
      if (last_half) begin
        rx_valid <= 1'b1;
        rx_data  <= cpha_q ? {rx_sr[DATA_W-2:0], miso} : rx_sr;
      end
    end
  end
`else
  logic unused_miso;

  assign unused_miso = miso;
  assign rx_valid    = 1'b0;
  assign rx_data     = '0;
`endif

endmodule

// File: tb/tb_spi_master_multi.sv
// Self-checking bench for spi_master_multi. miso is looped back from mosi.
// A scoreboard entry (data, select mask, mode, half-period, first-edge
// cycle) is pushed on every accepted word and checked by the sclk monitor.
module tb_spi_master_multi;

  localparam int DATA_W = 8;
  localparam int NUM_CS = 3;
  localparam int DIV_W  = 4;
  localparam int SEL_W  = 2;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic [NUM_CS-1:0] ncs;
    logic              cpol;
    logic              cpha;
    int                h;
    int                start;
  } exp_t;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              tx_ready;
  logic              tx_valid = 1'b0;
  logic [DATA_W-1:0] tx_data = '0;
  logic [SEL_W-1:0]  tx_cs_sel = '0;
  logic              tx_clear_cs = 1'b0;
  logic              cfg_cpol = 1'b0;
  logic              cfg_cpha = 1'b0;
  logic [DIV_W-1:0]  cfg_div = '0;
  logic              miso;
  logic              rx_valid;
  logic [DATA_W-1:0] rx_data;
  logic              sclk;
  logic              mosi;
  logic [NUM_CS-1:0] n_cs;

  exp_t sb[$];
  logic [NUM_CS-1:0] seg_val[$];
  int                seg_len[$];

  int compared = 0;
  int mismatched = 0;
  int cycle = 0;
  bit model_held = 0;
  int model_idx = 0;

  logic              prev_sclk = 1'b0;
  logic              prev_mosi = 1'b0;
  bit                armed = 0;
  int                edges = 0;
  int                last_cyc = 0;
  logic [DATA_W-1:0] bits = '0;
  int                words_done = 0;
  int                rx_pulses = 0;
  int                ncs_bad = 0;

  assign miso = mosi;

  spi_master_multi #(.DATA_W(DATA_W), .NUM_CS(NUM_CS), .DIV_W(DIV_W)) dut (
    .clock(clock), .reset(reset), .tx_ready(tx_ready), .tx_valid(tx_valid),
    .tx_data(tx_data), .tx_cs_sel(tx_cs_sel), .tx_clear_cs(tx_clear_cs),
    .cfg_cpol(cfg_cpol), .cfg_cpha(cfg_cpha), .cfg_div(cfg_div), .miso(miso),
    .rx_valid(rx_valid), .rx_data(rx_data), .sclk(sclk), .mosi(mosi), .n_cs(n_cs)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cycle <= cycle + 1;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Monitor: chip-select log, rx pulse count and per-word sclk/mosi checks.
  always @(negedge clock) begin
    exp_t e;
    if (rx_valid) rx_pulses++;
    if (n_cs != '1 && $countones(~n_cs) != 1) ncs_bad++;
    if (seg_val.size() == 0 || seg_val[seg_val.size()-1] != n_cs) begin
      seg_val.push_back(n_cs);
      seg_len.push_back(1);
    end else begin
      seg_len[seg_len.size()-1] = seg_len[seg_len.size()-1] + 1;
    end
    if (reset) begin
      armed = 0;
      edges = 0;
    end else if (sclk !== prev_sclk && sb.size() > 0) begin
      e = sb[0];
      if (!armed && sclk != e.cpol) begin
        armed = 1;
        edges = 0;
        bits  = '0;
        checkOutput("lead_latency", cycle, e.start);
      end else if (armed) begin
        checkOutput("half_period", cycle - last_cyc, e.h);
      end
      if (armed) begin
        edges++;
        last_cyc = cycle;
        if (sclk == (e.cpha ? e.cpol : ~e.cpol)) bits = {bits[DATA_W-2:0], prev_mosi};
        if (edges == 2 * DATA_W) begin
          checkOutput("mosi_word", bits, e.data);
          checkOutput("ncs_during", n_cs, e.ncs);
          checkOutput("mosi_idle", mosi, 0);
`ifdef SPI_MASTER_MULTI_RX_EN
          checkOutput("rx_valid", rx_valid, 1);
          checkOutput("rx_data", rx_data, e.data);
`else
          checkOutput("rx_valid", rx_valid, 0);
          checkOutput("rx_data", rx_data, 0);
`endif
          void'(sb.pop_front());
          armed = 0;
          words_done++;
        end
      end
    end
    prev_sclk = sclk;
    prev_mosi = mosi;
  end

  task automatic applyStimulus(input logic [DATA_W-1:0] data, input int sel, input logic clear,
                               input logic cpol, input logic cpha, input int div);
    exp_t e;
    int   c;
    int   n;
    bit   rdy;
    bit   accepted;
    c = (sel >= NUM_CS) ? NUM_CS - 1 : sel;
    @(negedge clock);
    tx_data     = data;
    tx_cs_sel   = SEL_W'(sel);
    tx_clear_cs = clear;
    cfg_cpol    = cpol;
    cfg_cpha    = cpha;
    cfg_div     = DIV_W'(div);
    tx_valid    = 1'b1;
    accepted    = 0;
    n           = 0;
    while (!accepted && n < 2000) begin
      rdy = tx_ready;
      @(posedge clock);
      #1;
      n++;
      if (rdy) accepted = 1;
      else @(negedge clock);
    end
    if (!accepted) begin
      checkOutput("accept_timeout", 0, 1);
      tx_valid = 1'b0;
      return;
    end
    e.data = data;
    e.ncs  = '1;
    e.ncs[c] = 1'b0;
    e.cpol = cpol;
    e.cpha = cpha;
    e.h    = div + 1;
    if (!model_held) e.start = cycle + 2 * e.h;
    else if (model_idx == c) e.start = cycle + e.h;
    else e.start = cycle + 3 * e.h;
    model_held = !clear;
    model_idx  = c;
    sb.push_back(e);
    @(negedge clock);
    tx_valid    = 1'b0;
    tx_data     = DATA_W'($urandom);
    tx_cs_sel   = SEL_W'($urandom);
    cfg_cpol    = 1'($urandom);
    cfg_cpha    = 1'($urandom);
    cfg_div     = DIV_W'($urandom);
  endtask

  task automatic waitDone();
    int n;
    n = 0;
    while (!(sb.size() == 0 && tx_ready) && n < 4000) begin
      @(negedge clock);
      n++;
    end
    if (!(sb.size() == 0 && tx_ready)) begin
      checkOutput("drain_timeout", 0, 1);
      sb.delete();
    end
    @(negedge clock);
  endtask

  task automatic clearLog();
    seg_val.delete();
    seg_len.delete();
  endtask

  function automatic int findSeg(input logic [NUM_CS-1:0] val);
    for (int i = 0; i < seg_val.size(); i++) if (seg_val[i] == val) return i;
    return -1;
  endfunction

  initial begin
    int idx;
    int lows;
    int n;

    #12;
    checkOutput("rst_ready", tx_ready, 0);
    checkOutput("rst_sclk", sclk, 0);
    checkOutput("rst_mosi", mosi, 0);
    checkOutput("rst_ncs", n_cs, 3'b111);
    checkOutput("rst_rx_valid", rx_valid, 0);
    checkOutput("rst_rx_data", rx_data, 0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    checkOutput("ready_pre_edge", tx_ready, 0);
    @(posedge clock);
    #1;
    checkOutput("ready_post_edge", tx_ready, 1);

    // Mode 0, div 0, 0xA5 to CS0 with release.
    waitDone();
    clearLog();
    applyStimulus(8'hA5, 0, 1'b1, 1'b0, 1'b0, 0);
    waitDone();
    idx = findSeg(3'b110);
    checkOutput("a5_cs_found", idx >= 0, 1);
    if (idx >= 0) begin
      checkOutput("a5_cs_len", seg_len[idx], 18);
      checkOutput("a5_cs_release", (idx + 1 < seg_val.size()) ? seg_val[idx+1] : 3'b000, 3'b111);
    end

    // Mode 3, div 2, loopback 0x3C.
    applyStimulus(8'h3C, 0, 1'b1, 1'b1, 1'b1, 2);
    waitDone();
    checkOutput("m3_sclk_idle", sclk, 1);

    // Two words to CS1, held across both.
    clearLog();
    applyStimulus(8'h5A, 1, 1'b0, 1'b0, 1'b0, 1);
    applyStimulus(8'hC3, 1, 1'b1, 1'b0, 1'b0, 1);
    waitDone();
    lows = 0;
    for (int i = 0; i < seg_val.size(); i++) if (seg_val[i] != 3'b111) lows++;
    checkOutput("hold_low_segs", lows, 1);

    // CS0 held, then switch to CS1.
    clearLog();
    applyStimulus(8'h96, 0, 1'b0, 1'b0, 1'b0, 1);
    applyStimulus(8'h69, 1, 1'b1, 1'b0, 1'b0, 1);
    waitDone();
    idx = findSeg(3'b110);
    checkOutput("sw_found", idx >= 0 && idx + 2 < seg_val.size(), 1);
    if (idx >= 0 && idx + 2 < seg_val.size()) begin
      checkOutput("sw_gap_val", seg_val[idx+1], 3'b111);
      checkOutput("sw_gap_len", seg_len[idx+1], 2);
      checkOutput("sw_new_cs", seg_val[idx+2], 3'b101);
    end

    // Out-of-range select maps to the last chip select.
    applyStimulus(8'h81, 3, 1'b1, 1'b0, 1'b1, 0);
    waitDone();

    // Random words; config is scrambled mid-word by applyStimulus.
    for (int k = 0; k < 10; k++) begin
      applyStimulus(DATA_W'($urandom), int'($urandom_range(0, 3)), 1'($urandom),
                    1'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
    end
    waitDone();

    // Asynchronous reset in the middle of a word.
    applyStimulus(8'hFF, 1, 1'b1, 1'b1, 1'b0, 3);
    n = 0;
    while (!(armed && edges == 4) && n < 500) begin
      @(negedge clock);
      n++;
    end
    checkOutput("mid_word_reached", armed && edges == 4, 1);
    @(posedge clock);
    #3;
    reset = 1'b1;
    #1;
    checkOutput("async_ncs", n_cs, 3'b111);
    checkOutput("async_sclk", sclk, 0);
    checkOutput("async_mosi", mosi, 0);
    checkOutput("async_rx_valid", rx_valid, 0);
    checkOutput("async_ready", tx_ready, 0);
    repeat (3) @(negedge clock);
    sb.delete();
    model_held = 0;
    reset = 1'b0;
    @(posedge clock);
    #1;
    checkOutput("ready_after_abort", tx_ready, 1);
    applyStimulus(8'h42, 2, 1'b1, 1'b0, 1'b0, 0);
    waitDone();

`ifdef SPI_MASTER_MULTI_RX_EN
    checkOutput("rx_pulse_count", rx_pulses, words_done);
`else
    checkOutput("rx_pulse_count", rx_pulses, 0);
`endif
    checkOutput("ncs_onehot_bad", ncs_bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
